// File: rtl/county_demand_if.sv
// Bundles the sensor input, the lamp-code feedback and the demand outputs of
// county_demand_detector.
interface county_demand_if #(
  parameter int unsigned CNT_W = 4
) ();
  logic             sensor_raw;
  logic [7:0]       main_road;
  logic [7:0]       county_road;
  logic             x;
  logic             present;
  logic [CNT_W-1:0] car_count;

  modport master (
    output sensor_raw, main_road, county_road,
    input  x, present, car_count
  );

  modport slave (
    input  sensor_raw, main_road, county_road,
    output x, present, car_count
  );
endinterface

// File: rtl/county_demand_detector.sv
// Turns the raw county-road loop sensor into the registered demand x for traffic_signal:
// it synchronises, debounces, queues vehicles, holds a minimum main green and caps service.
module county_demand_detector #(
  parameter int unsigned DEB_CYCLES     = 4,
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned MIN_MAIN_GREEN = 16,
  parameter int unsigned HEADWAY        = 8,
  parameter int unsigned MAX_SERVE      = 64
) (
  input  logic           clk,
  input  logic           reset,
  county_demand_if.slave bus
);
  localparam logic [7:0]       LampGreen = 8'h47;
  localparam logic [CNT_W-1:0] CntMax    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [15:0]      DebLast   = 16'(DEB_CYCLES - 1);
  localparam logic [15:0]      HoldInit  = 16'(MIN_MAIN_GREEN);
  localparam logic [15:0]      ServeInit = 16'(MAX_SERVE);
  localparam logic [15:0]      HeadLast  = 16'(HEADWAY - 1);

  typedef enum logic [1:0] {StMainHold, StWait, StServe} state_e;

  state_e           state_q;
  logic             sync1_q, sync2_q;
  logic             present_q, present_d;
  logic [15:0]      deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0] car_count_q, car_count_d;
  logic [15:0]      hold_q, serve_q, head_q;
  logic [7:0]       main_prev_q;
  logic             x_q;
  logic             main_green_rise, arrival, discharge, inc, dec;

  // Any cycle where the synced level matches present restarts the debounce window.
  always_comb begin
    present_d = present_q;
    deb_cnt_d = '0;
    if (sync2_q != present_q) begin
      if (deb_cnt_q == DebLast) begin
        present_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 16'd1;
      end
    end
  end

  assign arrival         = present_d & ~present_q;
  assign main_green_rise = (bus.main_road == LampGreen) && (main_prev_q != LampGreen);
  assign discharge       = (state_q == StServe) && !main_green_rise && (head_q == HeadLast);
  assign inc             = arrival && (car_count_q != CntMax);
  assign dec             = discharge && (car_count_q != '0);

  always_comb begin
    car_count_d = car_count_q;
    if (inc && !dec) begin
      car_count_d = car_count_q + CntOne;
    end else if (dec && !inc) begin
      car_count_d = car_count_q - CntOne;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      present_q   <= 1'b0;
      deb_cnt_q   <= '0;
      car_count_q <= '0;
      x_q         <= 1'b0;
      state_q     <= StMainHold;
      hold_q      <= HoldInit;
      serve_q     <= '0;
      head_q      <= '0;
      main_prev_q <= LampGreen;
    end else begin
      sync1_q     <= bus.sensor_raw;
      sync2_q     <= sync1_q;
      present_q   <= present_d;
      deb_cnt_q   <= deb_cnt_d;
      car_count_q <= car_count_d;
      main_prev_q <= bus.main_road;

      unique case (state_q)
        StWait:  x_q <= (car_count_q != '0);
        StServe: x_q <= (car_count_q != '0) && (serve_q != '0);
        default: x_q <= 1'b0;
      endcase

      if (main_green_rise) begin
        state_q <= StMainHold;
        hold_q  <= HoldInit;
      end else begin
        unique case (state_q)
          StMainHold: begin
            if (hold_q == 16'd1) begin
              state_q <= StWait;
            end else begin
              hold_q <= hold_q - 16'd1;
            end
          end
          StWait: begin
            if (bus.county_road == LampGreen) begin
              state_q <= StServe;
              serve_q <= ServeInit;
              head_q  <= '0;
            end
          end
          StServe: begin
            if (serve_q != '0) begin
              serve_q <= serve_q - 16'd1;
            end
            head_q <= (head_q == HeadLast) ? '0 : head_q + 16'd1;
          end
          default: state_q <= StMainHold;
        endcase
      end
    end
  end

  assign bus.x         = x_q;
  assign bus.present   = present_q;
  assign bus.car_count = car_count_q;
endmodule

// File: tb/tb_county_demand_detector.sv
// Scenario bench for county_demand_detector: each test pushes cycle-stamped expectations
// into a scoreboard queue, then drives stimulus and retires entries as their cycle arrives.
module tb_county_demand_detector;
  localparam logic [7:0] LampG = 8'h47;
  localparam logic [7:0] LampR = 8'h52;
  localparam int SelX = 0;
  localparam int SelPres = 1;
  localparam int SelCnt = 2;

  typedef struct {
    int          at;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  county_demand_if #(.CNT_W(4)) bus_if ();

  county_demand_detector #(
    .DEB_CYCLES(4), .CNT_W(4), .MIN_MAIN_GREEN(16), .HEADWAY(8), .MAX_SERVE(64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int   t;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  task automatic push(input int at, input int sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.at = at;
    e.sel = sel;
    e.exp = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SelX:    return {31'b0, bus_if.x};
      SelPres: return {31'b0, bus_if.present};
      default: return 32'(bus_if.car_count);
    endcase
  endfunction

  // High for 8 cycles every 16 cycles, n pulses starting at cycle first.
  function automatic logic pulses(input int tt, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      if (tt >= first + 16 * k && tt < first + 16 * k + 8) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_if.sensor_raw = 1'b0;
    bus_if.main_road = LampG;
    bus_if.county_road = LampR;
    tick();
    reset = 1'b0;
    t = 0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] obs;
    do_reset();
    push(0, SelX, 0, "reset_x");
    push(0, SelCnt, 0, "reset_count");
    push(0, SelPres, 0, "reset_present");
    push(16, SelX, 0, "hold_end_x");
    push(20, SelX, 0, "wait_empty_x");
    push(20, SelCnt, 0, "wait_empty_count");
    while (1'b1) begin
      while (sb.size() != 0 && sb[0].at <= t) begin
        e = sb.pop_front();
        obs = observe(e.sel);
        n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL %s t=%0d: got %0d expected %0d", e.name, t, obs, e.exp);
        end
      end
      if (t >= 20) break;
      tick();
    end
  endtask

  task automatic test_debounce();
    exp_t e;
    logic [31:0] obs;
    do_reset();
    push(0, SelPres, 0, "deb_init");
    push(26, SelPres, 0, "glitch_26");
    push(30, SelPres, 0, "glitch_30");
    push(35, SelPres, 0, "deb_early");
    push(36, SelPres, 1, "deb_rise");
    push(36, SelCnt, 1, "deb_arrival");
    push(36, SelX, 0, "deb_x_lag");
    push(37, SelX, 1, "deb_x_wait");
    push(45, SelPres, 1, "deb_fall_early");
    push(46, SelPres, 0, "deb_fall");
    push(50, SelCnt, 1, "deb_no_count_fall");
    while (1'b1) begin
      while (sb.size() != 0 && sb[0].at <= t) begin
        e = sb.pop_front();
        obs = observe(e.sel);
        n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL %s t=%0d: got %0d expected %0d", e.name, t, obs, e.exp);
        end
      end
      if (t >= 50) break;
      bus_if.sensor_raw = (t >= 20 && t < 23) || (t >= 30 && t < 40);
      tick();
    end
  endtask

  task automatic test_discharge();
    exp_t e;
    logic [31:0] obs;
    do_reset();
    push(16, SelX, 0, "dis_hold_x");
    push(17, SelX, 1, "dis_wait_x");
    push(40, SelCnt, 3, "dis_three");
    push(58, SelCnt, 3, "dis_pre1");
    push(59, SelCnt, 2, "dis_step1");
    push(66, SelCnt, 2, "dis_pre2");
    push(67, SelCnt, 1, "dis_step2");
    push(74, SelCnt, 1, "dis_pre3");
    push(75, SelCnt, 0, "dis_step3");
    push(75, SelX, 1, "dis_x_lag");
    push(76, SelX, 0, "dis_x_fall");
    while (1'b1) begin
      while (sb.size() != 0 && sb[0].at <= t) begin
        e = sb.pop_front();
        obs = observe(e.sel);
        n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL %s t=%0d: got %0d expected %0d", e.name, t, obs, e.exp);
        end
      end
      if (t >= 80) break;
      bus_if.sensor_raw = pulses(t, 2, 3);
      bus_if.county_road = (t >= 50) ? LampG : LampR;
      tick();
    end
  endtask

  task automatic test_saturate_maxout();
    exp_t e;
    logic [31:0] obs;
    do_reset();
    push(231, SelCnt, 14, "sat_14");
    push(232, SelCnt, 15, "sat_15");
    push(320, SelCnt, 15, "sat_hold");
    push(324, SelX, 1, "sat_wait_x");
    push(332, SelCnt, 15, "sat_pre_dis");
    push(333, SelCnt, 14, "sat_dis1");
    push(389, SelCnt, 7, "maxout_count");
    push(389, SelX, 1, "maxout_x_last");
    push(390, SelX, 0, "maxout_x");
    push(395, SelCnt, 7, "maxout_count_late");
    push(395, SelX, 0, "maxout_x_late");
    while (1'b1) begin
      while (sb.size() != 0 && sb[0].at <= t) begin
        e = sb.pop_front();
        obs = observe(e.sel);
        n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL %s t=%0d: got %0d expected %0d", e.name, t, obs, e.exp);
        end
      end
      if (t >= 400) break;
      bus_if.sensor_raw = pulses(t, 2, 20);
      bus_if.county_road = (t >= 324) ? LampG : LampR;
      tick();
    end
  endtask

  task automatic test_main_rise_and_coincide();
    exp_t e;
    logic [31:0] obs;
    do_reset();
    push(17, SelX, 1, "mr_wait_x");
    push(24, SelCnt, 2, "mr_count2");
    push(33, SelX, 1, "mr_x_lag");
    push(34, SelX, 0, "mr_hold_x");
    push(49, SelX, 0, "mr_hold_x_end");
    push(50, SelX, 1, "mr_release_x");
    push(60, SelCnt, 2, "co_pre");
    push(61, SelCnt, 2, "co_same_cycle");
    push(61, SelPres, 1, "co_present");
    push(69, SelCnt, 1, "co_next_dis");
    while (1'b1) begin
      while (sb.size() != 0 && sb[0].at <= t) begin
        e = sb.pop_front();
        obs = observe(e.sel);
        n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL %s t=%0d: got %0d expected %0d", e.name, t, obs, e.exp);
        end
      end
      if (t >= 72) break;
      bus_if.sensor_raw = pulses(t, 2, 2) || (t >= 55 && t < 63);
      bus_if.main_road = (t >= 30 && t < 32) ? LampR : LampG;
      bus_if.county_road = (t >= 52) ? LampG : LampR;
      tick();
    end
  endtask

  task automatic test_reset_in_serve();
    exp_t e;
    logic [31:0] obs;
    do_reset();
    push(72, SelCnt, 5, "rs_count5");
    push(74, SelCnt, 5, "rs_pre_count");
    push(74, SelX, 1, "rs_pre_x");
    push(75, SelCnt, 0, "rs_count");
    push(75, SelX, 0, "rs_x");
    push(75, SelPres, 0, "rs_present");
    push(100, SelX, 0, "rs_after_x");
    push(100, SelCnt, 0, "rs_after_count");
    while (1'b1) begin
      while (sb.size() != 0 && sb[0].at <= t) begin
        e = sb.pop_front();
        obs = observe(e.sel);
        n_checks++;
        if (obs !== e.exp) begin
          n_fail++;
          $display("FAIL %s t=%0d: got %0d expected %0d", e.name, t, obs, e.exp);
        end
      end
      if (t >= 100) break;
      bus_if.sensor_raw = pulses(t, 2, 5);
      bus_if.county_road = (t >= 72) ? LampG : LampR;
      reset = (t == 74);
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    bus_if.sensor_raw = 1'b0;
    bus_if.main_road = LampG;
    bus_if.county_road = LampR;
    t = 0;
    test_reset();
    test_debounce();
    test_discharge();
    test_saturate_maxout();
    test_main_rise_and_coincide();
    test_reset_in_serve();
    if (sb.size() != 0) begin
      n_fail += sb.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
